// File: rtl/tlb_pkg.sv
// ---------------------------------------------------------------------------
// tlb_pkg : shared FSM encoding and PTE field layout for the DTLB refill path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tlb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_FAULT = 3'd4,
      ST_DONE  = 3'd5
   } refill_state_t;

   localparam int PTE_VALID_BIT = 15;
   localparam int PTE_PPN_MSB   = 8;
   localparam int PTE_PPN_LSB   = 0;
   localparam int PAGE_SHIFT    = 7;

endpackage : tlb_pkg

`default_nettype wire

// File: rtl/tlb_victim_rr.sv
// ---------------------------------------------------------------------------
// tlb_victim_rr : round-robin victim pointer that skips the pinned boot lines
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tlb_victim_rr #(
   parameter int num_tlb_lines     = 4,
   parameter int first_replaceable = 2,
   localparam int idx_w = (num_tlb_lines > 1) ? $clog2(num_tlb_lines) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     advance,
   output logic [num_tlb_lines-1:0] onehot,
   output logic [idx_w-1:0]         index
);

   logic [idx_w-1:0] ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= idx_w'(first_replaceable);
      end else if (advance) begin
         // Wrap back to the first replaceable line, never into the pinned range.
         if (ptr == idx_w'(num_tlb_lines - 1))
            ptr <= idx_w'(first_replaceable);
         else
            ptr <= ptr + idx_w'(1);
      end
   end

   always_comb begin
      onehot      = '0;
      onehot[ptr] = 1'b1;
   end

   assign index = ptr;

endmodule : tlb_victim_rr

`default_nettype wire

// File: rtl/dtlb_refill.sv
// ---------------------------------------------------------------------------
// dtlb_refill : services DTLB misses by fetching the PTE and writing a line
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dtlb_refill
   import tlb_pkg::*;
#(
   parameter int                    addr_width        = 16,
   parameter int                    tag_bits_per_addr = 9,
   parameter int                    num_tlb_lines     = 4,
   parameter int                    first_replaceable = 2,
   parameter logic [addr_width-1:0] pt_base           = 16'h1000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         miss_valid,
   input  logic [tag_bits_per_addr-1:0] miss_vpn,
   output logic                         busy,
   output logic                         mem_req,
   output logic [addr_width-1:0]        mem_addr,
   input  logic                         mem_ack,
   input  logic [15:0]                  mem_rdata,
   output logic [num_tlb_lines-1:0]     tlb_we,
   output logic [tag_bits_per_addr-1:0] tlb_wr_virtual,
   output logic [tag_bits_per_addr-1:0] tlb_wr_physical,
   output logic                         tlb_wr_valid,
   output logic                         page_fault,
   output logic [tag_bits_per_addr-1:0] fault_vpn
);

   localparam int victim_w = (num_tlb_lines > 1) ? $clog2(num_tlb_lines) : 1;

   refill_state_t state, state_nx;

   logic [tag_bits_per_addr-1:0] vpn_r;
   logic [tag_bits_per_addr-1:0] ppn_r;
   logic [addr_width-1:0]        addr_r;
   logic [tag_bits_per_addr-1:0] fault_vpn_r;
   logic                         advance;
   logic [num_tlb_lines-1:0]     victim_onehot;
   logic [victim_w-1:0]          unused_victim_idx;
   logic                         unused_pte_bits;

   assign unused_pte_bits = ^mem_rdata[14:9];

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         vpn_r       <= '0;
         ppn_r       <= '0;
         addr_r      <= '0;
         fault_vpn_r <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && miss_valid) begin
            vpn_r  <= miss_vpn;
            // PTEs are 2 bytes; the sum wraps modulo the memory address space.
            addr_r <= pt_base + addr_width'({miss_vpn, 1'b0});
         end
         if (state == ST_WAIT && mem_ack) begin
            ppn_r <= tag_bits_per_addr'(mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB]);
            if (!mem_rdata[PTE_VALID_BIT])
               fault_vpn_r <= vpn_r;
         end
      end
   end

   always_comb begin
      state_nx     = state;
      busy         = 1'b1;
      mem_req      = 1'b0;
      tlb_wr_valid = 1'b0;
      page_fault   = 1'b0;
      advance      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (miss_valid)
               state_nx = ST_REQ;
         end
         ST_REQ: begin
            mem_req  = 1'b1;
            state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            mem_req = 1'b1;
            if (mem_ack)
               state_nx = mem_rdata[PTE_VALID_BIT] ? ST_WRITE : ST_FAULT;
         end
         ST_WRITE: begin
            tlb_wr_valid = 1'b1;
            advance      = 1'b1;
            state_nx     = ST_DONE;
         end
         ST_FAULT: begin
            page_fault = 1'b1;
            state_nx   = ST_DONE;
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = ST_IDLE;
         end
      endcase
   end

   tlb_victim_rr #(
      .num_tlb_lines     (num_tlb_lines),
      .first_replaceable (first_replaceable)
   ) u_victim (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .onehot  (victim_onehot),
      .index   (unused_victim_idx)
   );

   assign mem_addr        = addr_r;
   assign tlb_we          = tlb_wr_valid ? victim_onehot : '0;
   assign tlb_wr_virtual  = vpn_r;
   assign tlb_wr_physical = ppn_r;
   assign fault_vpn       = fault_vpn_r;

endmodule : dtlb_refill

`default_nettype wire

// File: tb/tb_dtlb_refill.sv
// ---------------------------------------------------------------------------
// tb_dtlb_refill : directed + randomized refills against a cycle-timing model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dtlb_refill;

   localparam int NUM   = 4;
   localparam int FIRST = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        miss_valid;
   logic [8:0]  miss_vpn;
   logic        mem_ack;
   logic [15:0] mem_rdata;

   logic        busy, mem_req, tlb_wr_valid, page_fault;
   logic [15:0] mem_addr;
   logic [3:0]  tlb_we;
   logic [8:0]  tlb_wr_virtual, tlb_wr_physical, fault_vpn;

   logic        busy2, mem_req2, tlb_wr_valid2, page_fault2;
   logic [15:0] mem_addr2;
   logic [3:0]  tlb_we2;
   logic [8:0]  tlb_wr_virtual2, tlb_wr_physical2, fault_vpn2;

   int checks   = 0;
   int failures = 0;
   int nref     = 0;          // valid refills since reset
   logic [8:0] last_fault = '0;

   always #5 clk = ~clk;

   dtlb_refill #(.first_replaceable(FIRST), .pt_base(16'h1000)) dut (
      .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_vpn(miss_vpn),
      .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .tlb_we(tlb_we), .tlb_wr_virtual(tlb_wr_virtual),
      .tlb_wr_physical(tlb_wr_physical), .tlb_wr_valid(tlb_wr_valid),
      .page_fault(page_fault), .fault_vpn(fault_vpn));

   // Second instance: wrapping page-table base and a single replaceable line.
   dtlb_refill #(.first_replaceable(NUM - 1), .pt_base(16'hFE00)) dut2 (
      .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_vpn(miss_vpn),
      .busy(busy2), .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .tlb_we(tlb_we2), .tlb_wr_virtual(tlb_wr_virtual2),
      .tlb_wr_physical(tlb_wr_physical2), .tlb_wr_valid(tlb_wr_valid2),
      .page_fault(page_fault2), .fault_vpn(fault_vpn2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; miss_valid = 1'b0; miss_vpn = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_mem_req", 32'(mem_req), 32'(0));
      chk("rst_page_fault", 32'(page_fault), 32'(0));
      chk("rst_wr_valid", 32'(tlb_wr_valid), 32'(0));
      chk("rst_tlb_we", 32'(tlb_we), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_wr_virtual", 32'(tlb_wr_virtual), 32'(0));
      chk("rst_wr_physical", 32'(tlb_wr_physical), 32'(0));
      chk("rst_fault_vpn", 32'(fault_vpn), 32'(0));
      reset = 1'b0;
      nref = 0;
      last_fault = '0;
   endtask

   // One complete refill starting in an idle cycle; w = WAIT cycles before ack.
   task automatic refill(input logic [8:0] vpn, input logic [15:0] pte, input int w, input bit noise);
      logic [15:0] a1, a2;
      logic [3:0]  we1;
      bit          valid;
      int          wr;
      valid = pte[15];
      a1  = 16'(32'h1000 + 32'(vpn) * 2);
      a2  = 16'(32'hFE00 + 32'(vpn) * 2);
      we1 = 4'(1 << (FIRST + nref % (NUM - FIRST)));
      wr  = 3 + w;
      chk("idle_busy", 32'(busy), 32'(0));
      miss_valid = 1'b1; miss_vpn = vpn; mem_ack = 1'b0;
      for (int k = 1; k <= 5 + w; k++) begin
         @(posedge clk);
         #1;
         if (k == wr && !valid) last_fault = vpn;
         chk("busy", 32'(busy), 32'(k <= 4 + w));
         chk("busy2", 32'(busy2), 32'(k <= 4 + w));
         chk("mem_req", 32'(mem_req), 32'(k <= 2 + w));
         if (k <= 2 + w) begin
            chk("mem_addr", 32'(mem_addr), 32'(a1));
            chk("mem_addr2", 32'(mem_addr2), 32'(a2));
         end
         chk("tlb_we", 32'(tlb_we), 32'((k == wr && valid) ? we1 : 4'b0000));
         chk("tlb_we2", 32'(tlb_we2), 32'((k == wr && valid) ? 4'b1000 : 4'b0000));
         chk("page_fault", 32'(page_fault), 32'(k == wr && !valid));
         chk("page_fault2", 32'(page_fault2), 32'(k == wr && !valid));
         chk("fault_vpn", 32'(fault_vpn), 32'(last_fault));
         if (k == wr && valid) begin
            chk("wr_virtual", 32'(tlb_wr_virtual), 32'(vpn));
            chk("wr_physical", 32'(tlb_wr_physical), 32'(pte[8:0]));
            chk("wr_valid", 32'(tlb_wr_valid), 32'(1));
         end else begin
            chk("wr_valid_idle", 32'(tlb_wr_valid), 32'(0));
         end
         miss_valid = (noise && k >= 2 && k <= 2 + w) ? 1'($urandom % 2) : 1'b0;
         miss_vpn   = noise ? 9'h1FF : 9'($urandom);
         mem_ack    = (k == 2 + w) || (noise && k == 1);
         mem_rdata  = (k == 2 + w) ? pte : 16'($urandom);
      end
      mem_ack = 1'b0;
      if (valid) nref++;
   endtask

   initial begin
      do_reset();
      refill(9'h012, 16'h8023, 2, 1'b0);
      chk("plan1_addr_const", 32'(mem_addr), 32'h1024);

      do_reset();
      refill(9'h020, 16'h8031, 0, 1'b0);
      refill(9'h021, 16'h8032, 1, 1'b0);
      refill(9'h022, 16'h8033, 0, 1'b0);

      do_reset();
      refill(9'h055, 16'h0023, 1, 1'b0);
      refill(9'h056, 16'h8077, 0, 1'b0);

      refill(9'h010, 16'hFE44, 2, 1'b1);
      refill(9'h1FF, 16'h8101, 1, 1'b0);
      chk("wrap_addr2_const", 32'(mem_addr2), 32'h01FE);

      // Reset while waiting for the PTE; a late ack must be ignored.
      do_reset();
      miss_valid = 1'b1; miss_vpn = 9'h033;
      @(posedge clk); #1;
      miss_valid = 1'b0;
      @(posedge clk); #1;
      chk("wait_mem_req", 32'(mem_req), 32'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rstwait_mem_req", 32'(mem_req), 32'(0));
      chk("rstwait_busy", 32'(busy), 32'(0));
      chk("rstwait_tlb_we", 32'(tlb_we), 32'(0));
      chk("rstwait_fault", 32'(page_fault), 32'(0));
      reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h8044;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("late_ack_tlb_we", 32'(tlb_we), 32'(0));
         chk("late_ack_busy", 32'(busy), 32'(0));
         chk("late_ack_mem_req", 32'(mem_req), 32'(0));
      end
      mem_ack = 1'b0;
      nref = 0;
      last_fault = '0;
      refill(9'h034, 16'h8045, 0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         logic [15:0] pte;
         pte = {1'($urandom % 4 != 0), 6'($urandom), 9'($urandom)};
         refill(9'($urandom), pte, int'($urandom % 4), 1'($urandom % 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dtlb_refill

`default_nettype wire

// File: doc/dtlb_refill.md
Name: dtlb_refill

Overview:
- Refill engine on the write side of the data TLB; the TLB lookup raises misses, this block services them.
- On a miss it latches the offending virtual page number (VPN) and reads the page-table entry (PTE) for that page from memory with a req/ack handshake.
- A valid PTE is written into one TLB line chosen round-robin. An invalid PTE raises a page fault.
- The pipeline stalls on `busy` while a refill is in flight.

Parameters:
- `addr_width`, 16, byte-address width of the memory port.
- `tag_bits_per_addr`, 9, VPN/PPN width (page = 128B).
- `num_tlb_lines`, 4, number of TLB entries.
- `first_replaceable`, 2, lowest line index the refill may overwrite; lines below it hold boot mappings and are never victimised.
- `pt_base`, 16'h1000, byte address of PTE for VPN 0.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset.
- `miss_valid`  in  1  lookup reports a miss this cycle (TLB `isHit`=0 on a live access).
- `miss_vpn`  in  tag_bits_per_addr  offending virtual page number.
- `busy`  out  1  refill in progress; the pipeline must hold the access.
- `mem_req`  out  1  PTE read request.
- `mem_addr`  out  addr_width  PTE byte address.
- `mem_ack`  in  1  read data valid.
- `mem_rdata`  in  16  PTE: bit15 valid, bits[8:0] PPN, rest ignored.
- `tlb_we`  out  num_tlb_lines  one-hot write enable to TLB lines.
- `tlb_wr_virtual`  out  tag_bits_per_addr  VPN to write.
- `tlb_wr_physical`  out  tag_bits_per_addr  PPN to write.
- `tlb_wr_valid`  out  1  valid bit to write (always 1 on a refill write).
- `page_fault`  out  1  one-cycle pulse when the PTE is invalid.
- `fault_vpn`  out  tag_bits_per_addr  VPN of the last fault; holds until the next fault.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `reset` is synchronous, active-high.
- Reset values:
  - FSM in IDLE.
  - `busy`, `mem_req`, `page_fault`, `tlb_wr_valid` all 0.
  - `tlb_we` = 0; `mem_addr`, `tlb_wr_virtual`, `tlb_wr_physical`, `fault_vpn` = 0.
  - Victim pointer = `first_replaceable`.
- IDLE:
  - If `miss_valid`=1, latch `miss_vpn` and go to REQ.
  - `busy` is registered and rises the cycle after the miss.
  - The lookup keeps `miss_valid` asserted until `busy` is seen.
- REQ:
  - `mem_req`=1, `mem_addr` = `pt_base` + (vpn << 1), truncated to `addr_width`. `busy`=1.
  - Go to WAIT.
- WAIT:
  - `mem_req` stays 1 and `mem_addr` stays stable until the cycle `mem_ack`=1.
  - On ack, register `mem_rdata` and drop `mem_req` next cycle.
  - If bit15=1 go to WRITE, else go to FAULT.
  - An ack in the same cycle as the request (REQ->WAIT edge) is not possible; an ack arriving in REQ is ignored.
- WRITE (one cycle):
  - `tlb_we` = one-hot(victim); `tlb_wr_virtual` = vpn; `tlb_wr_physical` = PTE[8:0]; `tlb_wr_valid`=1.
  - Victim advances: victim+1, wrapping from `num_tlb_lines`-1 back to `first_replaceable`.
  - Go to DONE.
- FAULT (one cycle):
  - `page_fault`=1, `fault_vpn` = vpn, no TLB write, victim unchanged.
  - Go to DONE.
- DONE (one cycle):
  - `busy`=1 so the TLB read register settles.
  - Then IDLE, with `busy`=0. The lookup retries the access.
- `miss_valid` outside IDLE is ignored; no queueing. A retried access that misses again starts a new refill.
- Minimum miss-to-`busy`-low latency with a zero-wait ack (ack in the first WAIT cycle) is 5 cycles: IDLE->REQ->WAIT->WRITE/FAULT->DONE->IDLE.
- Reset in any state returns to IDLE next edge: drops `mem_req` with no completion; no `tlb_we` or `page_fault` that cycle; victim returns to `first_replaceable`.
- `tlb_we` is never multi-hot and never selects a line below `first_replaceable`.
- If `first_replaceable` equals `num_tlb_lines`-1, the victim stays on that line every refill.

Decomposition:
- Shared package `tlb_pkg`:
  - FSM state encoding (IDLE, REQ, WAIT, WRITE, FAULT, DONE).
  - PTE field constants: valid bit 15, PPN bits [8:0].
  - Page-size shift, 7.
- Sub-module `tlb_victim_rr`: round-robin pointer with `first_replaceable` wrap, `advance` input, one-hot and binary outputs.

Test Plan:
- Reset, then `miss_vpn`=9'h012 with `miss_valid`; memory acks after 2 wait cycles with 16'h8023 -> `mem_addr`=16'h1024; `tlb_we`=4'b0100, `tlb_wr_virtual`=9'h012, `tlb_wr_physical`=9'h023 for exactly one cycle; `busy` low 7 cycles after the miss.
- Three consecutive valid refills (VPNs 9'h020, 9'h021, 9'h022) -> `tlb_we` sequence 4'b0100, 4'b1000, 4'b0100; lines 0 and 1 are never written.
- PTE 16'h0023 for VPN 9'h055 -> `page_fault` pulses once, `fault_vpn`=9'h055, `tlb_we` stays 0; the next valid refill still uses line 2.
- `miss_valid` toggled with `miss_vpn`=9'h1FF during WAIT of a refill for 9'h010 -> ignored; only 9'h010 is written.
- `reset` asserted while in WAIT with `mem_req` high -> `mem_req`=0 and `busy`=0 next cycle; a late `mem_ack` after reset causes no `tlb_we`.
- VPN 9'h1FF with `pt_base`=16'hFE00 -> `mem_addr`=16'h01FE (wraps modulo 2^16).
